pipe_trace_buffer: RTL
======================

Name: pipe_trace_buffer

Overview:
Synthesizable trace-capture block for the 16-bit pipelined CPU. It replaces per-cycle $display dumps of IF/ID/EX/M/WB signals with an on-chip circular buffer. The buffer records NUM_CH stage-signal channels plus a cycle timestamp, freezes on a trigger after a programmable post-trigger count, and is then drained through a simple read port. It sits beside the cpu core; the CPU testbench and debug logic drive arm/trigger and read it out.

Parameters:
DATA_W, 16, width of one traced channel
NUM_CH, 4, number of traced channels (e.g. PC, Instruction, ALUOutput, MemToRegMuxOutput)
DEPTH, 32, number of entries; power of two, >= 2
TS_W, 16, timestamp width
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
sample  in  NUM_CH*DATA_W  channel data; channel k at [k*DATA_W +: DATA_W]
sample_en  in  1  qualifies sample this cycle
arm  in  1  start new capture (pulse)
stop  in  1  force freeze (pulse)
trig_mode  in  1  0 = continuous (trig_in ignored), 1 = triggered
trig_in  in  1  trigger event
post_count  in  ADDR_W  samples to record after the trigger sample
rd_en  in  1  pop oldest entry (honoured only in DONE with count>0)
rd_data  out  NUM_CH*DATA_W+TS_W  {timestamp, channels}; valid with rd_valid
rd_valid  out  1  rd_data valid, one cycle after accepted rd_en
count  out  ADDR_W+1  entries held, saturates at DEPTH
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
triggered  out  1  trigger accepted since last arm

Behaviour:
- Reset: state=IDLE, count=0, wr_ptr=0, timestamp=0, post counter=0, rd_data=0, rd_valid=0, triggered=0. Storage contents not reset.
- Timestamp: free-running TS_W counter, cleared on accepted arm, increments every cycle in ARMED/POST, wraps modulo 2^TS_W, held in IDLE/DONE.
- IDLE: arm -> ARMED with count=0, wr_ptr=0, triggered=0, timestamp=0. All other inputs ignored.
- ARMED: each sample_en cycle writes {timestamp, sample} at wr_ptr; wr_ptr wraps at DEPTH-1 -> 0; count increments to DEPTH, then holds (oldest overwritten).
- ARMED with trig_mode=1 and trig_in: that cycle's sample is written if sample_en; triggered=1; if post_count=0 -> DONE, else -> POST with post counter=post_count.
- POST: each sample_en write decrements the post counter; the write that reaches 0 moves to DONE in the same edge. Samples without sample_en do not count. trig_in ignored.
- stop in ARMED or POST -> DONE next edge; a sample_en in that same cycle is still written. stop in IDLE/DONE is ignored.
- arm in ARMED/POST/DONE restarts the capture exactly as from IDLE. Previous contents are discarded (count=0). arm beats stop and trig_in in the same cycle.
- DONE: no writes. rd_en with count>0 reads entry (wr_ptr - count) mod DEPTH; rd_data/rd_valid appear the next cycle; count decrements. rd_en with count=0 gives rd_valid=0 and rd_data holds. rd_en outside DONE is ignored.
- Single-port storage is sufficient: writes happen only in ARMED/POST and reads only in DONE.
- Reset mid-capture or mid-readout returns to the reset state immediately; no partial readout is preserved.

Decomposition:
- Shared package trace_pkg: state encoding constants (TR_IDLE, TR_ARMED, TR_POST, TR_DONE); entry-layout helper localparams (ENTRY_W = NUM_CH*DATA_W+TS_W).
- One sub-module trace_ram: DEPTH x ENTRY_W, synchronous write, registered read, no reset. The controller FSM, pointers, timestamp and counters live in pipe_trace_buffer.

Test Plan:
- Config for all scenarios: DEPTH=8, NUM_CH=2, DATA_W=16, TS_W=16.
- Continuous wrap: arm, trig_mode=0, 12 sample_en cycles with ch0=0x0000..0x000B, then stop -> count=8, state=DONE; 8 rd_en give ch0 0x0004..0x000B, timestamps strictly +1; 9th rd_en gives rd_valid=0.
- Trigger with post: trig_mode=1, post_count=3, samples 0x10..0x1F, trig_in with sample 0x14 -> DONE after sample 0x17. Readout oldest-first 0x10..0x17, count=8, triggered=1.
- post_count=0: trigger on sample 0x20 -> state=DONE the next cycle; last entry read is 0x20; later sample_en are not recorded.
- Gapped samples: in POST, sample_en low for 5 cycles -> post counter unchanged, timestamps in the readout show a gap of 6.
- Arm/stop collision: arm and stop in the same cycle while in POST -> state=ARMED, count=0, timestamp=0, triggered=0.
- Async reset: assert reset mid-readout (count=5) without a clock edge -> state=0, count=0, rd_valid=0 immediately.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer: controller state encoding
// and the layout of one stored entry ({timestamp, channels}).
package trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_TS_W    = 16;
  localparam int DEF_ENTRY_W = DEF_NUM_CH * DEF_DATA_W + DEF_TS_W;

  function automatic int entry_width(input int num_ch, input int data_w, input int ts_w);
    return num_ch * data_w + ts_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Single-port trace storage: synchronous write, registered read, no reset.
// The read register only loads on re, so it holds its last value otherwise.
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 80,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace buffer for the pipelined CPU: captures timestamped channel
// samples, freezes on stop or after a post-trigger count, then drains oldest-first.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 32,
  parameter int TS_W   = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*DATA_W-1:0]      sample,
  input  logic                          sample_en,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          trig_mode,
  input  logic                          trig_in,
  input  logic [ADDR_W-1:0]             post_count,
  input  logic                          rd_en,
  output logic [NUM_CH*DATA_W+TS_W-1:0] rd_data,
  output logic                          rd_valid,
  output logic [ADDR_W:0]               count,
  output logic [1:0]                    state,
  output logic                          triggered
);

  localparam int ENTRY_W = entry_width(NUM_CH, DATA_W, TS_W);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  tr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, post_cnt, rd_addr, ram_addr;
  logic [ADDR_W:0]   cnt;
  logic [TS_W-1:0]   ts;
  logic              trig_q, valid_q, loaded;
  logic              capturing, wr_en, trig_hit, post_last, rd_accept;
  logic [ENTRY_W-1:0] ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= TR_IDLE;
    else       state_q <= state_d;
  end

  // arm restarts from any state and outranks stop/trigger in the same cycle
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = TR_ARMED;
    end else begin
      unique case (state_q)
        TR_IDLE:  state_d = TR_IDLE;
        TR_ARMED: if (stop) state_d = TR_DONE;
                  else if (trig_hit) state_d = (post_count == '0) ? TR_DONE : TR_POST;
        TR_POST:  if (stop || post_last) state_d = TR_DONE;
        TR_DONE:  state_d = TR_DONE;
      endcase
    end
  end

  always_comb begin
    capturing = (state_q == TR_ARMED) || (state_q == TR_POST);
    wr_en     = capturing && sample_en && !arm;
    trig_hit  = (state_q == TR_ARMED) && trig_mode && trig_in && !arm;
    post_last = (state_q == TR_POST) && wr_en && (post_cnt == ADDR_W'(1));
    rd_accept = (state_q == TR_DONE) && rd_en && (cnt != '0) && !arm;
  end

  // Oldest entry sits count slots behind the write pointer (mod DEPTH)
  assign rd_addr  = wr_ptr - cnt[ADDR_W-1:0];
  assign ram_addr = (state_q == TR_DONE) ? rd_addr : wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      cnt      <= '0;
      ts       <= '0;
      post_cnt <= '0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      valid_q <= rd_accept;
      if (rd_accept) loaded <= 1'b1;
      if (arm) begin
        wr_ptr <= '0;
        cnt    <= '0;
        ts     <= '0;
        trig_q <= 1'b0;
      end else begin
        if (capturing) ts <= ts + TS_W'(1);
        if (wr_en) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (cnt != FULL) cnt <= cnt + (ADDR_W + 1)'(1);
        end
        if (rd_accept) cnt <= cnt - (ADDR_W + 1)'(1);
        if (trig_hit) begin
          trig_q   <= 1'b1;
          post_cnt <= post_count;
        end else if (state_q == TR_POST && wr_en) begin
          post_cnt <= post_cnt - ADDR_W'(1);
        end
      end
    end
  end

  trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_accept),
    .addr  (ram_addr),
    .wdata ({ts, sample}),
    .rdata (ram_q)
  );

  // The RAM read register has no reset, so mask it until the first real read
  assign rd_data   = loaded ? ram_q : '0;
  assign rd_valid  = valid_q;
  assign count     = cnt;
  assign state     = state_q;
  assign triggered = trig_q;

endmodule
